uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped 8N1 UART peripheral on the PicoRV32 look-ahead bus, decoded at 0x1000_0010–0x1000_001F next to the byte output port. It buffers CPU writes in a TX FIFO and received bytes in an RX FIFO. It exposes a data register, a status register and a baud divisor register. Its read data feeds the system read-data mux.

## Interface
Parameters:
- DIV_RESET, 434: reset value of the baud divisor, in clocks per bit (50 MHz / 115200).
- TX_DEPTH, 8: TX FIFO entries; must be a power of 2, at least 2.
- RX_DEPTH, 8: RX FIFO entries; must be a power of 2, at least 2. Used only with UART_MMIO_RX_FIFO_EN.

Ports:
- clk_i  in  1  system clock. Single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- sel_i  in  1  register window selected (look-ahead address decode).
- addr_i  in  2  word offset: 0 DATA, 1 STATUS, 2 BAUD, 3 reserved.
- we_i  in  1  write strobe, qualified by sel_i.
- re_i  in  1  read strobe, qualified by sel_i.
- data_i  in  32  write data.
- data_o  out  32  registered read data.
- txd_o  out  1  serial output; idles high.
- rxd_i  in  1  asynchronous serial input.

## Operation
- DATA write: push data_i[7:0] to the TX FIFO. If the FIFO is full, drop the byte and set tx_ovf.
- DATA read: data_o = {23'b0, rx_valid, rx_byte}. The RX FIFO pops only when it is non-empty. A read of an empty FIFO returns 0 and changes no state.
- STATUS read bits:
  - 0 tx_full
  - 1 tx_empty (FIFO empty and shifter idle)
  - 2 rx_valid
  - 3 rx_ovr
  - 4 frame_err
  - 5 tx_ovf
  - all other bits 0
- STATUS write: write-1-to-clear on bits 3..5. All other bits are ignored.
- BAUD: 16-bit divisor, read/write. Writes of a value below 4 store 4. A new value takes effect at the next start bit; a frame already in progress keeps its old period.
- Reserved offset: reads 0; writes are ignored.
- TX FSM states: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE. Each state lasts div clocks. From STOP, the FSM goes straight to START if the FIFO is non-empty, so back-to-back frames have no idle gap.
- RX input conditioning: rxd_i passes through a 2-FF synchronizer.
- RX FSM states: IDLE → START → DATA → STOP.
  - IDLE: a synchronized falling edge enters START.
  - START: sample at div/2 (integer floor). If the line is high, treat it as a glitch and return to IDLE.
  - DATA: sample every div clocks, 8 bits.
  - STOP: sample once. If low, set frame_err and discard the byte. If high and the FIFO is full, set rx_ovr and discard the byte. Otherwise push the byte.
- Simultaneous events on the same clock:
  - Push and pop on the same FIFO: both occur and the count is unchanged.
  - Hardware set and software clear of the same flag: the set wins.
- Reset mid-frame: both FSMs abort. txd_o returns high on the next clock. Both FIFOs empty, all flags clear, divisor = DIV_RESET.

## Timing
- Register writes and pops take effect at the clk_i edge where sel_i and the strobe are high.
- data_o is valid the cycle after the read strobe, lining up with mem_ready.
- data_o holds its value until the next selected read. Reset value 0.
- TX latency: the start bit appears on txd_o 1 clock after a DATA write into an idle, empty block.
- RX latency: rx_valid rises at most 2 + div/2 clocks after the middle of the stop bit (synchronizer plus push).
- Frame length is exactly 10·div clocks.

## Configuration
- UART_MMIO_RX_FIFO_EN defined: the RX path uses an RX_DEPTH-entry FIFO.
- UART_MMIO_RX_FIFO_EN undefined: the RX path uses a single holding register. The overrun rule still applies, with full meaning 1 entry held. The register map is unchanged.

## Structure
- Package uart_mmio_pkg holds:
  - register offsets (DATA, STATUS, BAUD)
  - STATUS bit indices
  - TX/RX FSM state encodings
  - minimum divisor constant (4)
- One sub-module, uart_mmio_fifo: a synchronous FIFO parameterised by depth and width, with full/empty flags. It is instantiated for TX, and for RX when the macro is set.

## Test plan
- Reset, then read STATUS → 0x0000_0002; read BAUD → 434; txd_o = 1.
- Set BAUD = 8, write DATA 0xA5 → txd_o shows start bit, bits 1,0,1,0,0,1,0,1, stop bit, 8 clocks each, 80 clocks total. Then STATUS bit1 = 1.
- With BAUD = 8, write 9 bytes with no gaps → first 8 accepted, tx_ovf = 1, and frames go out back-to-back. Write STATUS 0x20 → tx_ovf = 0.
- With BAUD = 8, drive frame 0x3C on rxd_i → rx_valid = 1. DATA read → 0x0000_013C; a second read → 0.
- With BAUD = 8, drive a frame with a low stop bit → frame_err = 1 and rx_valid stays 0. With the FIFO filled to capacity, one more frame → rx_ovr = 1 and the FIFO contents are unchanged.
- Assert rst_i in the middle of a TX frame → txd_o = 1 the next clock, STATUS = 0x0000_0002, BAUD = 434.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared constants for the uart_mmio peripheral: register offsets, STATUS bit
// positions, TX/RX FSM encodings and the minimum baud divisor.
package uart_mmio_pkg;

  // Word offsets inside the 16-byte register window
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegBaud   = 2'd2;

  // STATUS bit positions
  localparam int unsigned StTxFull   = 0;
  localparam int unsigned StTxEmpty  = 1;
  localparam int unsigned StRxValid  = 2;
  localparam int unsigned StRxOvr    = 3;
  localparam int unsigned StFrameErr = 4;
  localparam int unsigned StTxOvf    = 5;

  // TX FSM encodings
  localparam logic [1:0] TxIdle  = 2'd0;
  localparam logic [1:0] TxStart = 2'd1;
  localparam logic [1:0] TxData  = 2'd2;
  localparam logic [1:0] TxStop  = 2'd3;

  // RX FSM encodings
  localparam logic [1:0] RxIdle  = 2'd0;
  localparam logic [1:0] RxStart = 2'd1;
  localparam logic [1:0] RxData  = 2'd2;
  localparam logic [1:0] RxStop  = 2'd3;

  // Smallest divisor that still leaves room for a mid-bit sample
  localparam logic [15:0] MinDiv = 16'd4;

  // STATUS low bits; first member is the most significant bit
  typedef struct packed {
    logic tx_ovf;
    logic frame_err;
    logic rx_ovr;
    logic rx_valid;
    logic tx_empty;
    logic tx_full;
  } status_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < MinDiv) ? MinDiv : v;
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// Look-ahead register bus between the CPU side and the uart_mmio window.
interface uart_mmio_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel,
    output addr,
    output we,
    output re,
    output wdata,
    input  rdata
  );

  modport slave (
    input  sel,
    input  addr,
    input  we,
    input  re,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/uart_mmio_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// Push while full and pop while empty are ignored; push and pop together keep
// the count unchanged.
module uart_mmio_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; Depth is a power of 2 so pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CntW'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: DATA / STATUS / BAUD registers, TX FIFO, RX buffer.
// Build option: define UART_MMIO_RX_FIFO_EN to buffer received bytes in an
// RX_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int unsigned DIV_RESET = 434,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  uart_mmio_if.slave bus,
  output logic       txd_o,
  input  logic       rxd_i
);

  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 ||
      RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_mmio: TX_DEPTH and RX_DEPTH must be powers of 2, at least 2");
  end

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic wr_data, wr_status, wr_baud, rd_data, rd_sel;

  assign rd_sel    = bus.sel & bus.re;
  assign wr_data   = bus.sel & bus.we & (bus.addr == RegData);
  assign wr_status = bus.sel & bus.we & (bus.addr == RegStatus);
  assign wr_baud   = bus.sel & bus.we & (bus.addr == RegBaud);
  assign rd_data   = rd_sel & (bus.addr == RegData);

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:16];

  // Baud divisor
  logic [15:0] baud_q;

  // Divisor register, clamped on write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_q <= 16'(DIV_RESET);
    end else if (wr_baud) begin
      baud_q <= clamp_div(bus.wdata[15:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  logic       tx_full, tx_fifo_empty, tx_push, tx_pop;
  logic [7:0] tx_head;

  assign tx_push = wr_data & ~tx_full;

  uart_mmio_fifo #(
    .Depth (TX_DEPTH),
    .Width (8)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push),
    .wdata_i (bus.wdata[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_fifo_empty)
  );

  logic [1:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d;
  logic        tx_slot_end;

  assign tx_slot_end = (tx_cnt_q == tx_div_q - 16'd1);

  // TX next state. The byte stays in the FIFO until its data bits are out, so
  // the FIFO depth bounds every byte the CPU has handed over.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        if (!tx_fifo_empty) begin
          tx_state_d = TxStart;
          tx_sh_d    = tx_head;
          tx_div_d   = baud_q;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
        end
      end
      TxStart: begin
        if (tx_slot_end) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxData: begin
        if (tx_slot_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            txd_d      = 1'b1;
            tx_pop     = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxStop: begin
        if (tx_slot_end) begin
          tx_cnt_d = '0;
          // Chain straight into the next frame to avoid an idle gap
          if (!tx_fifo_empty) begin
            tx_state_d = TxStart;
            tx_sh_d    = tx_head;
            tx_div_d   = baud_q;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = TxIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_state_d = TxIdle;
        txd_d      = 1'b1;
      end
    endcase
  end

  // TX state registers; txd idles high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= MinDiv;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  assign txd_o = txd_q;

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;

  // Two-flop synchronizer plus previous-value flop for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic        frame_err_set, rx_ovr_set;
  logic [7:0]  rx_head;
  logic        rx_slot_end;

  assign rx_slot_end = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_pop      = rd_data & ~rx_empty;

  // RX next state: mid-bit sampling with glitch rejection on the start bit
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_div_d      = rx_div_q;
    rx_bit_d      = rx_bit_q;
    rx_sh_d       = rx_sh_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    rx_ovr_set    = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_div_d   = baud_q;
          // The edge detector already spent one clock of the start bit
          rx_cnt_d   = 16'd1;
        end
      end
      RxStart: begin
        if (rx_cnt_q == (rx_div_q >> 1)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxData: begin
        if (rx_slot_end) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxStop: begin
        if (rx_slot_end) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          if (!rx_sync_q) begin
            frame_err_set = 1'b1;
          end else if (rx_full) begin
            rx_ovr_set = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= MinDiv;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

`ifdef UART_MMIO_RX_FIFO_EN
  uart_mmio_fifo #(
    .Depth (RX_DEPTH),
    .Width (8)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .wdata_i (rx_sh_q),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );
`else
  logic [7:0] rx_hold_q;
  logic       rx_hold_vld_q;

  // Single-entry receive buffer; push only happens while it is empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_hold_q     <= '0;
      rx_hold_vld_q <= 1'b0;
    end else if (rx_push) begin
      rx_hold_q     <= rx_sh_q;
      rx_hold_vld_q <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_vld_q <= 1'b0;
    end
  end

  assign rx_full  = rx_hold_vld_q;
  assign rx_empty = ~rx_hold_vld_q;
  assign rx_head  = rx_hold_q;
`endif

  // ---------------------------------------------------------------------------
  // Sticky flags and read data
  // ---------------------------------------------------------------------------
  logic tx_ovf_q, rx_ovr_q, frame_err_q;
  logic clr_ovr, clr_ferr, clr_ovf;

  assign clr_ovr  = wr_status & bus.wdata[StRxOvr];
  assign clr_ferr = wr_status & bus.wdata[StFrameErr];
  assign clr_ovf  = wr_status & bus.wdata[StTxOvf];

  // Write-1-to-clear flags; a hardware set in the same cycle wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_ovf_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_ovf_q    <= (tx_ovf_q & ~clr_ovf) | (wr_data & tx_full);
      rx_ovr_q    <= (rx_ovr_q & ~clr_ovr) | rx_ovr_set;
      frame_err_q <= (frame_err_q & ~clr_ferr) | frame_err_set;
    end
  end

  status_t     status;
  logic [31:0] rd_mux;
  logic [31:0] rdata_q;

  // STATUS word and read-data mux
  always_comb begin
    status.tx_ovf    = tx_ovf_q;
    status.frame_err = frame_err_q;
    status.rx_ovr    = rx_ovr_q;
    status.rx_valid  = ~rx_empty;
    status.tx_empty  = tx_fifo_empty & (tx_state_q == TxIdle);
    status.tx_full   = tx_full;
    rd_mux = '0;
    case (bus.addr)
      RegData:   rd_mux = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
      RegStatus: rd_mux = {26'd0, status};
      RegBaud:   rd_mux = {16'd0, baud_q};
      default:   rd_mux = '0;
    endcase
  end

  // Read data holds until the next selected read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_sel) begin
      rdata_q <= rd_mux;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register reads, TX frames decoded by a
// monitor against a queue of written bytes, RX frames driven on rxd and
// checked against a queue when read back.
module tb_uart_mmio;
  import uart_mmio_pkg::*;

`ifdef UART_MMIO_RX_FIFO_EN
  localparam int RxCap = 8;
`else
  localparam int RxCap = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic txd;
  logic rxd;

  uart_mmio_if bus ();

  uart_mmio #(
    .DIV_RESET (434),
    .TX_DEPTH  (8),
    .RX_DEPTH  (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .txd_o (txd),
    .rxd_i (rxd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tb_div = 8;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  bit mon_en    = 1'b0;
  bit b2b_chk   = 1'b0;
  bit have_last = 1'b0;
  int last_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // TX monitor: decodes frames on txd and pops the expected byte
  initial begin : tx_monitor
    logic [7:0] got;
    logic [7:0] exp_b;
    int d;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        d = tb_div;
        if (b2b_chk && have_last) begin
          total++;
          if (cyc - last_start != 10 * d) begin
            bad++;
            $display("FAIL tx_gap: got %0d clocks between starts, want %0d",
                     cyc - last_start, 10 * d);
          end
        end
        have_last  = 1'b1;
        last_start = cyc;
        repeat (d / 2) @(negedge clk);
        total++;
        if (txd !== 1'b0) begin
          bad++;
          $display("FAIL tx_start_bit: got %b want 0", txd);
        end
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          got[i] = txd;
        end
        repeat (d) @(negedge clk);
        total++;
        if (txd !== 1'b1) begin
          bad++;
          $display("FAIL tx_stop_bit: got %b want 1", txd);
        end
        total++;
        if (tx_exp_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected_frame: got %02h want no frame", got);
        end else begin
          exp_b = tx_exp_q.pop_front();
          if (got !== exp_b) begin
            bad++;
            $display("FAIL tx_byte: got %02h want %02h", got, exp_b);
          end
        end
        repeat (d - d / 2 - 1) @(negedge clk);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.re = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.sel = 1'b0; bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = fr[i];
      repeat (tb_div - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
    repeat (tb_div - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rxd = 1'b1;
    bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;
    do_reset();
    total++;
    if (bus.rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %08h want 0", bus.rdata); end
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL reset_status: got %08h want 00000002", r); end
    bus_read(RegBaud, r);
    total++;
    if (r !== 32'd434) begin bad++; $display("FAIL reset_baud: got %0d want 434", r); end
  endtask

  task automatic test_baud();
    logic [31:0] r;
    bus_write(RegBaud, 32'd2);
    bus_read(RegBaud, r);
    total++;
    if (r !== 32'd4) begin bad++; $display("FAIL baud_clamp: got %0d want 4", r); end
    bus_write(RegBaud, 32'h0001_0008);
    bus_read(RegBaud, r);
    total++;
    if (r !== 32'd8) begin bad++; $display("FAIL baud_write: got %0d want 8", r); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL reserved_read: got %08h want 0", r); end
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL reserved_write: status %08h want 00000002", r); end
  endtask

  task automatic test_tx_frame();
    logic [31:0] r;
    logic [9:0]  fr;
    fr = {1'b1, 8'hA5, 1'b0};
    mon_en = 1'b1;
    tx_exp_q.push_back(8'hA5);
    bus_write(RegData, 32'hA5);
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL tx_latency_early: got %b want 1", txd); end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      total++;
      if (txd !== fr[i / 8]) begin
        bad++;
        $display("FAIL tx_wave: clock %0d got %b want %b", i, txd, fr[i / 8]);
      end
    end
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL tx_done_status: got %08h want 00000002", r); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] r;
    int waited;
    b2b_chk   = 1'b1;
    have_last = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      bus.sel = 1'b1; bus.we = 1'b1; bus.addr = RegData; bus.wdata = 32'(8'h81 + 8'(i));
      if (i < 8) tx_exp_q.push_back(8'h81 + 8'(i));
      @(negedge clk);
    end
    bus.sel = 1'b0; bus.we = 1'b0;
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h21) begin bad++; $display("FAIL tx_ovf_set: got %08h want 00000021", r); end
    bus_write(RegStatus, 32'h20);
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h01) begin bad++; $display("FAIL tx_ovf_clear: got %08h want 00000001", r); end
    waited = 0;
    while (tx_exp_q.size() != 0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (tx_exp_q.size() != 0) begin
      bad++;
      $display("FAIL tx_drain: got %0d bytes pending want 0", tx_exp_q.size());
    end
    repeat (20) @(negedge clk);
    b2b_chk = 1'b0;
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL tx_drain_status: got %08h want 00000002", r); end
  endtask

  task automatic test_rx_frame();
    logic [31:0] r;
    logic [7:0]  e;
    rx_exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h6) begin bad++; $display("FAIL rx_valid_status: got %08h want 00000006", r); end
    bus_read(RegData, r);
    e = rx_exp_q.pop_front();
    total++;
    if (r !== {23'd0, 1'b1, e}) begin
      bad++;
      $display("FAIL rx_data: got %08h want %08h", r, {23'd0, 1'b1, e});
    end
    bus_read(RegData, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL rx_empty_read: got %08h want 0", r); end
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL rx_after_pop: got %08h want 00000002", r); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] r;
    logic [7:0]  e;
    send_rx(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h12) begin bad++; $display("FAIL rx_frame_err: got %08h want 00000012", r); end
    bus_write(RegStatus, 32'h10);
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL rx_ferr_clear: got %08h want 00000002", r); end
    for (int i = 0; i < RxCap; i++) begin
      rx_exp_q.push_back(8'h10 + 8'(i));
      send_rx(8'h10 + 8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h6) begin bad++; $display("FAIL rx_filled: got %08h want 00000006", r); end
    send_rx(8'hEE, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'hE) begin bad++; $display("FAIL rx_overrun: got %08h want 0000000e", r); end
    for (int i = 0; i < RxCap; i++) begin
      bus_read(RegData, r);
      e = rx_exp_q.pop_front();
      total++;
      if (r !== {23'd0, 1'b1, e}) begin
        bad++;
        $display("FAIL rx_kept_data: got %08h want %08h", r, {23'd0, 1'b1, e});
      end
    end
    bus_read(RegData, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL rx_ovr_dropped: got %08h want 0", r); end
    bus_write(RegStatus, 32'h08);
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL rx_ovr_clear: got %08h want 00000002", r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    mon_en = 1'b0;
    bus_write(RegData, 32'h5A);
    repeat (30) @(negedge clk);
    total++;
    if (txd !== 1'b0) begin bad++; $display("FAIL mid_frame_bit: got %b want 0", txd); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd_next: got %b want 1", txd); end
    total++;
    if (bus.rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata2: got %08h want 0", bus.rdata); end
    @(negedge clk);
    rst = 1'b0;
    bus_read(RegStatus, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL reset_status2: got %08h want 00000002", r); end
    bus_read(RegBaud, r);
    total++;
    if (r !== 32'd434) begin bad++; $display("FAIL reset_baud2: got %0d want 434", r); end
    repeat (40) @(negedge clk);
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL reset_tx_quiet: got %b want 1", txd); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_baud();
    test_tx_frame();
    test_tx_overflow();
    test_rx_frame();
    test_rx_errors();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
